// File: rtl/pu_pkg.sv
// pu_pkg: shared definitions for the PU floating-point datapath.
//  - default field widths, exponent bias function
//  - fp_t struct {sign, exp, man} at the default 16-bit format
//  - canonical qNaN / signed Inf / signed zero generators (width generic)
//  - normalise + round-to-nearest-even + pack helper used by mul and add
// Width-generic helpers work on a WRK_W-bit scratch word and return the packed
// value in its low 1+exp_w+man_w bits; callers truncate to their data width.
package pu_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int WRK_W     = 64;

  typedef logic [WRK_W-1:0] wrk_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: {0, all-ones exponent, 1, zeros}
  function automatic wrk_t fp_qnan(input int exp_w, input int man_w);
    wrk_t r;
    r = ((wrk_t'(1) << exp_w) - wrk_t'(1)) << man_w;
    r = r | (wrk_t'(1) << (man_w - 1));
    return r;
  endfunction

  function automatic wrk_t fp_inf(input logic sign, input int exp_w, input int man_w);
    return (wrk_t'(sign) << (exp_w + man_w)) |
           (((wrk_t'(1) << exp_w) - wrk_t'(1)) << man_w);
  endfunction

  function automatic wrk_t fp_zero(input logic sign, input int exp_w, input int man_w);
    return wrk_t'(sign) << (exp_w + man_w);
  endfunction

  // sig: unsigned significand; its bit WRK_W-1 has weight 2^(exp_b - bias).
  // A zero significand (exact cancellation) yields +0. Results below the
  // normal range flush to signed zero, results above saturate to signed Inf.
  function automatic wrk_t fp_norm_round_pack(input logic sign, input int exp_b,
                                              input wrk_t sig, input int exp_w,
                                              input int man_w);
    wrk_t s;
    wrk_t kept;
    wrk_t tmp;
    int   lz;
    int   e;
    logic guard;
    logic sticky;
    if (sig == '0) return '0;
    lz = 0;
    for (int i = 0; i < WRK_W; i++) begin
      if (sig[i]) lz = WRK_W - 1 - i;
    end
    s      = sig << lz;
    e      = exp_b - lz;
    kept   = s >> (WRK_W - 1 - man_w);
    tmp    = s >> (WRK_W - 2 - man_w);
    guard  = tmp[0];
    sticky = ((s << (man_w + 2)) != '0);
    if (guard && (sticky || kept[0])) kept = kept + wrk_t'(1);
    // Rounding carried out of the significand: renormalise by one
    if ((kept >> (man_w + 1)) != '0) begin
      kept = kept >> 1;
      e    = e + 1;
    end
    if (e >= (1 << exp_w) - 1) return fp_inf(sign, exp_w, man_w);
    if (e <= 0) return fp_zero(sign, exp_w, man_w);
    return (wrk_t'(sign) << (exp_w + man_w)) | (wrk_t'(e) << man_w) |
           (kept & ((wrk_t'(1) << man_w) - wrk_t'(1)));
  endfunction

endpackage

// File: rtl/pu_fp_mul.sv
// pu_fp_mul: combinational floating-point multiply with RNE rounding,
// subnormal flush, and IEEE special cases (NaN, Inf, Inf*0).
// Ports:
//  a, b  in   DW  operands
//  p     out  DW  rounded product
//  ovf   out  1   product became Inf although both operands were finite
module pu_fp_mul
  import pu_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  localparam int DW    = 1 + EXP_W + MAN_W
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] p,
  output logic          ovf
);

  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  logic             sa, sb, sp;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]    prod;
  wrk_t             res;
  int               exp_b;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign sp     = sa ^ sb;
  // exp==0 covers true zero and subnormals, which are flushed to zero
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);
  assign prod   = {1'b1, ma} * {1'b1, mb};

  always_comb begin
    res   = '0;
    ovf   = 1'b0;
    exp_b = 0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res = fp_qnan(EXP_W, MAN_W);
    end else if (a_inf || b_inf) begin
      res = fp_inf(sp, EXP_W, MAN_W);
    end else if (a_zero || b_zero) begin
      res = fp_zero(sp, EXP_W, MAN_W);
    end else begin
      // prod is in [1,4); its top bit carries weight 2^(ea+eb-2*bias+1)
      exp_b = int'(ea) + int'(eb) - BIAS + 1;
      res   = fp_norm_round_pack(sp, exp_b, wrk_t'(prod) << (WRK_W - PW), EXP_W, MAN_W);
      ovf   = (res[DW-2 -: EXP_W] == '1);
    end
    p = DW'(res);
  end

endmodule

// File: rtl/pu_dot_seq.sv
// pu_dot_seq: streaming floating-point dot product, one result per vector.
// Two stages: S1 registers the rounded product, S2 accumulates it with the
// aligner/adder/normaliser below. After the last element is taken the input
// side holds off until the result has been handed over.
// Ports:
//  clk, reset_n (async, active-low), clear (synchronous abort)
//  vec_len              elements per vector, sampled with the first element
//  in_valid/in_ready    operand handshake, a/b operands
//  out_valid/out_ready  result handshake, result and sticky out_ovf
//  elem_cnt             elements accepted in the current vector
module pu_dot_seq
  import pu_pkg::*;
#(
  parameter  int EXP_W   = EXP_W_DEF,
  parameter  int MAN_W   = MAN_W_DEF,
  parameter  int MAX_LEN = 256,
  localparam int DW      = 1 + EXP_W + MAN_W,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    result,
  output logic             out_ovf,
  output logic [CNT_W-1:0] elem_cnt
);

  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  logic             accept, last_elem;
  logic [CNT_W-1:0] len_sat, len_eff, len_reg, cnt_reg;
  logic             hold_reg;
  logic [DW-1:0]    prod, prod_reg, acc_reg, result_reg, sum, add_x;
  logic             prod_ovf, p_ovf_reg, p_valid_reg, p_first_reg, p_last_reg;
  logic             sum_ovf, flag_next, flag_reg, out_valid_reg, out_ovf_reg;

  assign in_ready  = reset_n & ~hold_reg & ~clear;
  assign accept    = in_valid & in_ready;
  assign len_sat   = (vec_len == '0) ? CNT_W'(1) : (vec_len > MAX_LEN_C) ? MAX_LEN_C : vec_len;
  // len_reg is only loaded by the first accept, so that element uses vec_len directly
  assign len_eff   = (cnt_reg == '0) ? len_sat : len_reg;
  assign last_elem = (cnt_reg == len_eff - CNT_W'(1));

  pu_fp_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_mul (
    .a   (a),
    .b   (b),
    .p   (prod),
    .ovf (prod_ovf)
  );

  // ---------------- S2 adder: add_x + prod_reg ----------------
  logic             sx, sy, s_big, sticky_lsb;
  logic [EXP_W-1:0] ex, ey, e_big, e_small;
  logic [MAN_W-1:0] mx, my, m_big, m_small;
  logic             x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  wrk_t             sig_big, sig_small, small_sh, sum_sig, add_res;
  int               shamt;

  // The first product of a vector is added to +0, which restarts the sum
  assign add_x  = p_first_reg ? '0 : acc_reg;
  assign {sx, ex, mx} = add_x;
  assign {sy, ey, my} = prod_reg;
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);
  assign x_inf  = (ex == '1) && (mx == '0);
  assign y_inf  = (ey == '1) && (my == '0);
  assign x_nan  = (ex == '1) && (mx != '0);
  assign y_nan  = (ey == '1) && (my != '0);

  always_comb begin
    add_res    = '0;
    sum_ovf    = 1'b0;
    s_big      = sx;
    e_big      = ex;
    m_big      = mx;
    e_small    = ey;
    m_small    = my;
    shamt      = 0;
    sig_big    = '0;
    sig_small  = '0;
    small_sh   = '0;
    sum_sig    = '0;
    sticky_lsb = 1'b0;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      add_res = fp_qnan(EXP_W, MAN_W);
    end else if (x_inf) begin
      add_res = fp_inf(sx, EXP_W, MAN_W);
    end else if (y_inf) begin
      add_res = fp_inf(sy, EXP_W, MAN_W);
    end else if (x_zero && y_zero) begin
      add_res = fp_zero(sx & sy, EXP_W, MAN_W);   // -0 only when both are -0
    end else if (x_zero) begin
      add_res = wrk_t'(prod_reg);
    end else if (y_zero) begin
      add_res = wrk_t'(add_x);
    end else begin
      if ({ey, my} > {ex, mx}) begin
        s_big   = sy;
        e_big   = ey;
        m_big   = my;
        e_small = ex;
        m_small = mx;
      end
      // Leading one at bit WRK_W-2 leaves bit WRK_W-1 free for the carry
      shamt     = int'(e_big) - int'(e_small);
      sig_big   = wrk_t'({1'b1, m_big}) << (WRK_W - 2 - MAN_W);
      sig_small = wrk_t'({1'b1, m_small}) << (WRK_W - 2 - MAN_W);
      if (shamt >= WRK_W) begin
        small_sh   = '0;
        sticky_lsb = 1'b1;
      end else begin
        small_sh   = sig_small >> shamt;
        sticky_lsb = ((sig_small & ((wrk_t'(1) << shamt) - wrk_t'(1))) != '0);
      end
      // Shifted-out bits fold into the LSB, far below the rounding position
      small_sh[0] = small_sh[0] | sticky_lsb;
      sum_sig     = (sx == sy) ? (sig_big + small_sh) : (sig_big - small_sh);
      add_res     = fp_norm_round_pack(s_big, int'(e_big) + 1, sum_sig, EXP_W, MAN_W);
      sum_ovf     = (add_res[DW-2 -: EXP_W] == '1);
    end
    sum = DW'(add_res);
  end

  assign flag_next = (~p_first_reg & flag_reg) | p_ovf_reg | sum_ovf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg       <= '0;
      len_reg       <= '0;
      hold_reg      <= 1'b0;
      prod_reg      <= '0;
      p_ovf_reg     <= 1'b0;
      p_valid_reg   <= 1'b0;
      p_first_reg   <= 1'b0;
      p_last_reg    <= 1'b0;
      acc_reg       <= '0;
      flag_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      out_ovf_reg   <= 1'b0;
    end else if (clear) begin
      cnt_reg       <= '0;
      hold_reg      <= 1'b0;
      p_valid_reg   <= 1'b0;
      acc_reg       <= '0;
      flag_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      p_valid_reg <= accept;
      if (accept) begin
        prod_reg    <= prod;
        p_ovf_reg   <= prod_ovf;
        p_first_reg <= (cnt_reg == '0);
        p_last_reg  <= last_elem;
        if (cnt_reg == '0) len_reg <= len_sat;
        cnt_reg <= last_elem ? '0 : cnt_reg + CNT_W'(1);
        if (last_elem) hold_reg <= 1'b1;
      end
      if (p_valid_reg) begin
        acc_reg  <= sum;
        flag_reg <= flag_next;
        if (p_last_reg) begin
          out_valid_reg <= 1'b1;
          result_reg    <= sum;
          out_ovf_reg   <= flag_next;
        end
      end
      // hold is never set while a result is pending, so this cannot collide
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        hold_reg      <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign out_ovf   = out_ovf_reg;
  assign elem_cnt  = cnt_reg;

endmodule

// File: tb/tb_pu_dot_seq.sv
// Directed testbench for pu_dot_seq (default 16-bit format, MAX_LEN 256).
module tb_pu_dot_seq;

  localparam int DW    = 16;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] vec_len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    a = '0;
  logic [DW-1:0]    b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    result;
  logic             out_ovf;
  logic [CNT_W-1:0] elem_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pu_dot_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .vec_len   (vec_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_ovf   (out_ovf),
    .elem_cnt  (elem_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic push(input logic [DW-1:0] av, input logic [DW-1:0] bv, input int len);
    int guard;
    guard    = 0;
    vec_len  = CNT_W'(len);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("push_ready_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after the last push: checks the two-cycle latency, the
  // result, and that the handshake drops out_valid.
  task automatic expect_result(input string tag, input logic [DW-1:0] er, input logic eo);
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_result"}, 32'(result), 32'(er));
    check_eq({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
    check_eq({tag, "_cnt"}, 32'(elem_cnt), 32'd0);
    $display("vector %s: result=0x%04h ovf=%0b (want 0x%04h ovf=%0b)", tag, result, out_ovf, er, eo);
    @(negedge clk);
    check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("rst_elem_cnt", 32'(elem_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

    // T1: 2.25*5 + 3*(-2.5) = 3.75
    push(16'h4080, 16'h4500, 2);
    check_eq("t1_cnt_mid", 32'(elem_cnt), 32'd1);
    push(16'h4200, 16'hC100, 2);
    expect_result("t1", 16'h4380, 1'b0);

    // T2: single-element vectors, accumulator restarts each time
    push(16'h4080, 16'h4500, 1);
    expect_result("t2a", 16'h49A0, 1'b0);
    push(16'h4200, 16'hC100, 1);
    expect_result("t2b", 16'hC780, 1'b0);

    // T3: finite overflow in multiply, sticky flag, cleared next vector
    push(16'h7BFF, 16'h4000, 2);
    push(16'h3C00, 16'h3C00, 2);
    expect_result("t3a", 16'h7C00, 1'b1);
    push(16'h3C00, 16'h3C00, 1);
    expect_result("t3b", 16'h3C00, 1'b0);

    // T4: Inf*0 and Inf-Inf give canonical qNaN
    push(16'h7C00, 16'h0000, 1);
    expect_result("t4a", 16'h7E00, 1'b0);
    push(16'h7C00, 16'h3C00, 2);
    push(16'hFC00, 16'h3C00, 2);
    expect_result("t4b", 16'h7E00, 1'b0);

    // Boundaries: vec_len 0 means 1, RNE in mul and add, flush, cancellation
    push(16'h4000, 16'h4000, 0);
    expect_result("len0", 16'h4400, 1'b0);
    push(16'h3C01, 16'h3C01, 1);
    expect_result("mul_rne", 16'h3C02, 1'b0);
    push(16'h3C01, 16'h3C00, 2);
    push(16'h1000, 16'h3C00, 2);
    expect_result("add_tie_up", 16'h3C02, 1'b0);
    push(16'h3C00, 16'h3C00, 2);
    push(16'h1000, 16'h3C00, 2);
    expect_result("add_tie_even", 16'h3C00, 1'b0);
    push(16'h0400, 16'h3800, 1);
    expect_result("sub_res_flush", 16'h0000, 1'b0);
    push(16'h0001, 16'h3C00, 1);
    expect_result("sub_in_flush", 16'h0000, 1'b0);
    push(16'h3C00, 16'h3C00, 2);
    push(16'hBC00, 16'h3C00, 2);
    expect_result("cancel", 16'h0000, 1'b0);

    // T5: back-pressure on the result side
    out_ready = 1'b0;
    push(16'h3C00, 16'h3C00, 3);
    push(16'h4000, 16'h3C00, 3);
    push(16'h3C00, 16'h3C00, 3);
    @(negedge clk);
    vec_len  = CNT_W'(1);
    a        = 16'h4000;
    b        = 16'h3C00;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
      check_eq("t5_hold_result", 32'(result), 32'h4400);
      check_eq("t5_hold_ready", 32'(in_ready), 32'd0);
      check_eq("t5_hold_cnt", 32'(elem_cnt), 32'd0);
      @(negedge clk);
    end
    $display("vector t5a: held result=0x%04h (want 0x4400)", result);
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_release_valid", 32'(out_valid), 32'd0);
    check_eq("t5_release_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    expect_result("t5b", 16'h4000, 1'b0);

    // T6: clear mid-vector
    push(16'h3C00, 16'h3C00, 4);
    push(16'h3C00, 16'h3C00, 4);
    check_eq("t6_cnt_before_clear", 32'(elem_cnt), 32'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    #1;
    check_eq("t6_clear_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("t6_clear_cnt", 32'(elem_cnt), 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("t6_clear_no_valid", 32'(seen), 32'd0);
    $display("vector t6a: cleared after 2 of 4, out_valid seen %0d times", seen);

    // T6: asynchronous reset mid-vector
    push(16'h3C00, 16'h3C00, 4);
    push(16'h3C00, 16'h3C00, 4);
    check_eq("t6_cnt_before_rst", 32'(elem_cnt), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_cnt", 32'(elem_cnt), 32'd0);
    check_eq("t6_rst_ready", 32'(in_ready), 32'd0);
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("t6_rst_no_valid", 32'(seen), 32'd0);
    $display("vector t6b: reset after 2 of 4, out_valid seen %0d times", seen);
    push(16'h3C00, 16'h4000, 1);
    expect_result("t6c", 16'h4000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
